// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and baud helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int bit_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid, the transmitter drives ready.
interface uart_tx_fifo_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Full and empty come from the occupancy counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally; count tracks net push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter: FIFO-buffered bytes serialised as 8 data bits,
// optional parity, 1 or 2 stop bits, frames sent back to back.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_fifo_ctrl_if.slave           bus,
    output logic                         tx,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int BIT_TICKS = bit_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int TW        = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (BIT_TICKS < 2) begin : g_bad_baud
        $error("CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_t   state, state_d;
    logic [TW-1:0] tick, tick_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, shreg_d;
    logic          par, par_d;
    logic          tx_d;
    logic          tick_end;
    logic          load;
    logic          full;
    logic          empty;
    logic [7:0]    head;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.tx_valid && bus.tx_ready),
        .pop   (load),
        .din   (bus.tx_data),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.tx_ready = !full;
    assign tx_busy      = (state != ST_IDLE);
    assign tick_end     = (tick == TICK_LAST);

    // Next-state, bit sequencing, pop decision and next line level.
    always_comb begin
        state_d = state;
        tick_d  = tick;
        bit_d   = bit_idx;
        shreg_d = shreg;
        par_d   = par;
        load    = 1'b0;
        tx_d    = 1'b1;
        if (state != ST_IDLE) tick_d = tick_end ? '0 : tick + 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) load = 1'b1;
            end
            ST_START: begin
                if (tick_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick_end) begin
                    par_d   = par ^ shreg[0];
                    shreg_d = shreg >> 1;
                    bit_d   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (tick_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (tick_end) begin
                    if (bit_idx == STOP_LAST) begin
                        if (!empty) load = 1'b1;
                        else state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_idx + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_START;
            tick_d  = '0;
            bit_d   = '0;
            shreg_d = head;
            par_d   = (PARITY == PARITY_ODD);
        end
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset idles the line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            bit_idx <= bit_d;
            shreg   <= shreg_d;
            par     <= par_d;
            tx      <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: four configurations, scoreboard of
// pushed bytes checked against a serial-line receiver model.
module tb_uart_tx_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [3:0]      valid = '0;
    logic [3:0]      rdy;
    logic [3:0]      txl;
    logic [3:0]      busy;
    logic [7:0]      data [4];
    logic [3:0][4:0] cnt;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo_ctrl_if bus ();
        assign bus.tx_data  = data[g];
        assign bus.tx_valid = valid[g];
        assign rdy[g]       = bus.tx_ready;
        uart_tx_fifo_ctrl #(
            .CLOCK_FREQ (1_000_000),
            .BAUD_RATE  (100_000),
            .PARITY     (g == 1 ? 2 : (g == 2 ? 1 : 0)),
            .STOP_BITS  (g == 3 ? 2 : 1),
            .FIFO_DEPTH (16)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .tx         (txl[g]),
            .tx_busy    (busy[g]),
            .fifo_count (cnt[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] sb [$];
    logic [7:0] stim [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int par_of(input int s);
        return s == 1 ? 2 : (s == 2 ? 1 : 0);
    endfunction

    function automatic int stop_of(input int s);
        return s == 3 ? 2 : 1;
    endfunction

    // Drive every byte in stim, holding valid until each is accepted.
    task automatic send(input int s, input bit chk_full);
        int i;
        int n;
        i = 0;
        @(negedge clk);
        while (stim.size() > 0) begin
            data[s]  = stim[0];
            valid[s] = 1'b1;
            n = 0;
            while (!rdy[s] && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                check("push_timeout", rdy[s], 1);
                stim.delete();
                break;
            end
            sb.push_back(stim.pop_front());
            @(negedge clk);
            i++;
            if (chk_full && i == 17) begin
                check("full_ready", rdy[s], 0);
                check("full_count", cnt[s], 16);
            end
        end
        valid[s] = 1'b0;
    endtask

    // Receive one frame from the line, compare against the scoreboard.
    task automatic recv(input int s, output int gap, output logic busy_last);
        int n;
        logic [7:0] b;
        logic [7:0] exp;
        n = 0;
        b = '0;
        busy_last = 1'b0;
        while (txl[s] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        if (n >= 5000) check("rx_timeout", txl[s], 0);
        check("rx_busy_start", busy[s], 1);
        repeat (5) @(negedge clk);
        check("rx_start", txl[s], 0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = txl[s];
        end
        check("sb_nonempty", sb.size() > 0, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : ~b;
        check("rx_data", b, exp);
        if (par_of(s) != 0) begin
            repeat (10) @(negedge clk);
            check("rx_parity", txl[s], par_of(s) == 2 ? ^exp : ~^exp);
        end
        for (int k = 0; k < stop_of(s); k++) begin
            repeat (10) @(negedge clk);
            check("rx_stop", txl[s], 1);
        end
        repeat (4) @(negedge clk);
        busy_last = busy[s];
        @(negedge clk);
    endtask

    // Single byte on an idle link: latency, content and frame length.
    task automatic single(input int s, input logic [7:0] d);
        int gap;
        logic bl;
        stim.push_back(d);
        send(s, 1'b0);
        check("lat_tx_idle", txl[s], 1);
        check("lat_busy_idle", busy[s], 0);
        recv(s, gap, bl);
        check("lat_gap", gap, 1);
        check("len_busy_last", bl, 1);
        check("len_busy_end", busy[s], 0);
        check("len_tx_end", txl[s], 1);
    endtask

    initial begin
        int gap;
        int lows;
        logic bl;
        logic [7:0] first;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", txl[0], 1);
        check("rst_ready", rdy[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_count", cnt[0], 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        single(0, 8'hA5);
        single(1, 8'h07);
        single(2, 8'h07);
        single(2, 8'h3C);

        stim.push_back(8'h00);
        stim.push_back(8'hFF);
        fork
            send(0, 1'b0);
            begin
                recv(0, gap, bl);
                recv(0, gap, bl);
                check("b2b_gap", gap, 0);
                check("b2b_busy_end", busy[0], 0);
            end
        join

        for (int i = 0; i < 20; i++) stim.push_back(8'(i * 29 + 3));
        fork
            send(0, 1'b1);
            for (int i = 0; i < 20; i++) recv(0, gap, bl);
        join
        check("fill_drained", cnt[0], 0);

        single(3, 8'h55);
        for (int i = 0; i < 18; i++) stim.push_back(8'(i * 53 + 17));
        fork
            send(3, 1'b1);
            for (int i = 0; i < 18; i++) recv(3, gap, bl);
        join

        first = 8'hA6;
        stim.push_back(first);
        for (int i = 1; i < 5; i++) stim.push_back(8'(i));
        send(0, 1'b0);
        check("mid_queued", cnt[0], 4);
        repeat (42) @(negedge clk);
        check("mid_bit3", txl[0], first[3]);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", txl[0], 1);
        check("mid_rst_count", cnt[0], 0);
        check("mid_rst_ready", rdy[0], 1);
        check("mid_rst_busy", busy[0], 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!txl[0] || busy[0]) lows++;
        end
        check("post_rst_quiet", lows, 0);
        check("post_rst_count", cnt[0], 0);

        check("sb_final_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
